multicycle_controller: RTL and testbench

Multi-cycle control sequencer for the processor datapath: steps each instruction through fetch, decode, execute, memory and writeback states over a shared single-port memory. It drives the same datapath control lines as the single-cycle opcode decoder, plus instruction-fetch, PC-update and memory-handshake controls. It sits between the instruction register (IR), the register file, the ALU and the memory port.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/opcode_class_decode.sv | 24 ++
 rtl/multicycle_controller.sv | 128 ++++++++++++
 tb/tb_multicycle_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the processor control path: opcodes, ALU ops,
// multi-cycle states, instruction classes and the datapath control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_SUB = 6'd3;
  localparam logic [5:0] OP_SW  = 6'd4;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_OR  = 6'd6;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} aluop_e;

  typedef enum logic [3:0] {
    RST_IDLE, FETCH, DECODE, EXEC_R, EXEC_A, MEM, WB_R, WB_L, TRAP
  } state_e;

  typedef enum logic [1:0] {CLS_R, CLS_M_LOAD, CLS_M_STORE, CLS_ILLEGAL} class_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for the state being entered; IRWrite/PCWrite are not
  // here because they depend on mem_ready in the same cycle.
  function automatic ctrl_t ctrl_for(state_e s, logic [1:0] cls, logic [1:0] alu);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  c.mem_read = 1'b1;
      EXEC_R: c.aluop = alu;
      EXEC_A: c.alu_src = 1'b1;
      MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = (cls == CLS_M_LOAD);
        c.mem_write = (cls == CLS_M_STORE);
      end
      WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.aluop     = alu;
      end
      WB_L: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier shared by the single- and multi-cycle paths.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] cls,
  output logic [1:0] alu_op
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_ADD: cls = CLS_R;
      OP_SUB: begin cls = CLS_R; alu_op = ALU_SUB; end
      OP_AND: begin cls = CLS_R; alu_op = ALU_AND; end
      OP_OR:  begin cls = CLS_R; alu_op = ALU_OR;  end
      OP_LW:  cls = CLS_M_LOAD;
      OP_SW:  cls = CLS_M_STORE;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback over a
// shared single-port memory with a bounded memory wait and sticky error flags.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [1:0]       ALUop,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state, nxt;
  ctrl_t             ctrl_q, ctrl_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        cls_d, alu_d;
  logic [WAIT_W-1:0] wait_q;
  logic              mem_phase, wait_hit, retire;

  // DECODE classifies the live opcode; every later state uses the latched copy.
  assign op_d = (state == DECODE) ? opcode : op_q;

  opcode_class_decode u_dec (.opcode(op_d), .cls(cls_d), .alu_op(alu_d));

  assign mem_phase = (state == FETCH) || (state == MEM);
  // A ready in the final allowed cycle still completes the access.
  assign wait_hit  = mem_phase && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      RST_IDLE: nxt = FETCH;
      FETCH:
        if (mem_ready)     nxt = DECODE;
        else if (wait_hit) nxt = TRAP;
      DECODE:
        case (cls_d)
          CLS_R:                   nxt = EXEC_R;
          CLS_M_LOAD, CLS_M_STORE: nxt = EXEC_A;
          default:                 nxt = TRAP;
        endcase
      EXEC_R: nxt = WB_R;
      EXEC_A: nxt = MEM;
      MEM:
        if (mem_ready) begin
          if (cls_d == CLS_M_LOAD) nxt = WB_L;
          else begin
            nxt    = FETCH;
            retire = 1'b1;
          end
        end else if (wait_hit) nxt = TRAP;
      WB_R, WB_L: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      TRAP:    nxt = TRAP;
      default: nxt = TRAP;
    endcase
    ctrl_d = ctrl_for(nxt, cls_d, alu_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST_IDLE;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             op_q <= '0;
    else if (state == DECODE) op_q <= opcode;
  end

  // Zero outside FETCH/MEM, so it is always clear on entry to either.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    wait_q <= '0;
    else if (mem_ready || !mem_phase) wait_q <= '0;
    else                             wait_q <= wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      if (state == DECODE && nxt == TRAP) illegal_op <= 1'b1;
      if (wait_hit)                       bus_error  <= 1'b1;
    end
  end

  assign PCWrite  = (state == FETCH) && mem_ready;
  assign IRWrite  = (state == FETCH) && mem_ready;
  assign IorD     = ctrl_q.iord;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign ALUSrc   = ctrl_q.alu_src;
  assign RegWrite = ctrl_q.reg_write;
  assign ALUop    = ctrl_q.aluop;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: cycle-by-cycle vector table for the instruction mix, plus
// hand sequences for timeout, ready-at-limit, async reset abort and wrap.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b1;

  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite;
  logic        RegDst, MemToReg, ALUSrc, RegWrite, illegal_op, bus_error;
  logic [1:0]  ALUop;
  logic [15:0] retired;

  logic        s_pcw, s_irw, s_iord, s_mr, s_mw, s_rd, s_m2r, s_as, s_rw, s_ill, s_be;
  logic [1:0]  s_alu;
  logic [2:0]  s_ret;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUop(ALUop), .illegal_op(illegal_op),
    .bus_error(bus_error), .retired(retired)
  );

  // Narrow counter copy so wraparound is reachable in a short run.
  multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_pcw), .IRWrite(s_irw), .IorD(s_iord), .MemRead(s_mr),
    .MemWrite(s_mw), .RegDst(s_rd), .MemToReg(s_m2r), .ALUSrc(s_as),
    .RegWrite(s_rw), .ALUop(s_alu), .illegal_op(s_ill),
    .bus_error(s_be), .retired(s_ret)
  );

  localparam logic [12:0] Z    = 13'h0000;
  localparam logic [12:0] PCW  = 13'h1000;
  localparam logic [12:0] IRW  = 13'h0800;
  localparam logic [12:0] IORD = 13'h0400;
  localparam logic [12:0] MR   = 13'h0200;
  localparam logic [12:0] MW   = 13'h0100;
  localparam logic [12:0] RD   = 13'h0080;
  localparam logic [12:0] M2R  = 13'h0040;
  localparam logic [12:0] AS   = 13'h0020;
  localparam logic [12:0] RW   = 13'h0010;
  localparam logic [12:0] ILL  = 13'h0002;
  localparam logic [12:0] BE   = 13'h0001;
  localparam logic [12:0] FR   = PCW | IRW | MR;
  localparam logic [12:0] FW   = MR;
  localparam logic [12:0] EXA  = AS;
  localparam logic [12:0] MEMR = IORD | MR;
  localparam logic [12:0] MEMW = IORD | MW;
  localparam logic [12:0] WBL  = M2R | RW;

  function automatic logic [12:0] alu(input int a);
    return 13'(a) << 2;
  endfunction
  function automatic logic [12:0] wbr(input int a);
    return RD | RW | alu(a);
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [12:0] exp;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  logic [12:0] outs;
  assign outs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegDst, MemToReg,
                 ALUSrc, RegWrite, ALUop, illegal_op, bus_error};

  task automatic check(input string nm, input logic [12:0] exp, input logic [15:0] ret);
    total++;
    if (outs !== exp || retired !== ret) begin
      bad++;
      $display("FAIL %s: outs=%b retired=%0d, want outs=%b retired=%0d",
               nm, outs, retired, exp, ret);
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [12:0] exp, input logic [15:0] ret, input string nm);
    @(posedge clk);
    #1;
    reset_n   = rst;
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check(nm, exp, ret);
  endtask

  task automatic do_reset(input string nm);
    step(1'b0, 6'd0, 1'b1, Z, 16'd0, {nm, "_rst"});
    step(1'b1, 6'd0, 1'b1, Z, 16'd0, {nm, "_idle"});
  endtask

  task automatic add_vec(input logic rst, input logic [5:0] op, input logic rdy,
                         input logic [12:0] exp, input logic [15:0] ret);
    vec_t v;
    v = '{rst, op, rdy, exp, ret};
    tbl.push_back(v);
  endtask

  initial begin
    // Reset, then add/sub/and/or, lw with 3 waits, sw, illegal opcode 7.
    add_vec(0, 6'd0,  1, Z,       0);
    add_vec(1, 6'd0,  1, Z,       0);
    add_vec(1, 6'd1,  1, FR,      0);
    add_vec(1, 6'd1,  1, Z,       0);
    add_vec(1, 6'd1,  1, alu(0),  0);
    add_vec(1, 6'd1,  1, wbr(0),  0);
    add_vec(1, 6'd3,  1, FR,      1);
    add_vec(1, 6'd3,  1, Z,       1);
    add_vec(1, 6'h3f, 1, alu(1),  1);  // live opcode garbage: latched sub must hold
    add_vec(1, 6'h3f, 1, wbr(1),  1);
    add_vec(1, 6'd5,  0, FW,      2);
    add_vec(1, 6'd5,  1, FR,      2);
    add_vec(1, 6'd5,  1, Z,       2);
    add_vec(1, 6'd2,  1, alu(2),  2);
    add_vec(1, 6'd2,  1, wbr(2),  2);
    add_vec(1, 6'd6,  1, FR,      3);
    add_vec(1, 6'd6,  1, Z,       3);
    add_vec(1, 6'd6,  1, alu(3),  3);
    add_vec(1, 6'd6,  1, wbr(3),  3);
    add_vec(1, 6'd2,  1, FR,      4);
    add_vec(1, 6'd2,  1, Z,       4);
    add_vec(1, 6'd2,  1, EXA,     4);
    add_vec(1, 6'd2,  0, MEMR,    4);
    add_vec(1, 6'd2,  0, MEMR,    4);
    add_vec(1, 6'd2,  0, MEMR,    4);
    add_vec(1, 6'd2,  1, MEMR,    4);
    add_vec(1, 6'd2,  1, WBL,     4);
    add_vec(1, 6'd4,  1, FR,      5);
    add_vec(1, 6'd4,  1, Z,       5);
    add_vec(1, 6'd4,  1, EXA,     5);
    add_vec(1, 6'd4,  1, MEMW,    5);
    add_vec(1, 6'd7,  1, FR,      6);
    add_vec(1, 6'd7,  1, Z,       6);
    add_vec(1, 6'd7,  1, ILL,     6);
    add_vec(1, 6'd1,  1, ILL,     6);
    add_vec(1, 6'd1,  1, ILL,     6);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].exp, tbl[i].ret, $sformatf("vec%0d", i));

    // Fetch never acknowledged: bus error after 16 waiting cycles.
    do_reset("to");
    for (int i = 0; i < 16; i++) step(1, 6'd1, 0, FW, 0, $sformatf("to_wait%0d", i));
    step(1, 6'd1, 0, BE, 0, "to_trap");
    step(1, 6'd1, 1, BE, 0, "to_stay");

    // Ready on the 16th cycle wins over the timeout.
    do_reset("lim");
    for (int i = 0; i < 15; i++) step(1, 6'd1, 0, FW, 0, $sformatf("lim_wait%0d", i));
    step(1, 6'd1, 1, FR,     0, "lim_ready");
    step(1, 6'd1, 1, Z,      0, "lim_dec");
    step(1, 6'd1, 1, alu(0), 0, "lim_exec");
    step(1, 6'd1, 1, wbr(0), 0, "lim_wb");
    step(1, 6'd1, 1, FR,     1, "lim_next");

    // Reset asserted mid-MEM of sw drops MemWrite without a clock edge.
    do_reset("ab");
    step(1, 6'd4, 1, FR,   0, "ab_fetch");
    step(1, 6'd4, 1, Z,    0, "ab_dec");
    step(1, 6'd4, 1, EXA,  0, "ab_exa");
    step(1, 6'd4, 0, MEMW, 0, "ab_mem");
    #2 reset_n = 1'b0;
    #1 check("ab_async", Z, 0);
    step(1, 6'd1, 1, Z,      0, "ab_idle");
    step(1, 6'd1, 1, FR,     0, "ab_refetch");
    step(1, 6'd1, 1, Z,      0, "ab_dec2");
    step(1, 6'd1, 1, alu(0), 0, "ab_exec2");
    step(1, 6'd1, 1, wbr(0), 0, "ab_wb2");
    step(1, 6'd1, 1, FR,     1, "ab_fetch3");

    // Eight adds: the 3-bit counter reaches 7 then wraps to 0.
    do_reset("wr");
    for (int i = 0; i < 8; i++) begin
      step(1, 6'd1, 1, FR, 16'(i), $sformatf("wr_f%0d", i));
      if (i == 7) begin
        total++;
        if (s_ret !== 3'd7) begin
          bad++;
          $display("FAIL wr_pre: small retired=%0d, want 7", s_ret);
        end
      end
      step(1, 6'd1, 1, Z,      16'(i), $sformatf("wr_d%0d", i));
      step(1, 6'd1, 1, alu(0), 16'(i), $sformatf("wr_e%0d", i));
      step(1, 6'd1, 1, wbr(0), 16'(i), $sformatf("wr_w%0d", i));
    end
    step(1, 6'd1, 1, FR, 16'd8, "wr_last");
    total++;
    if (s_ret !== 3'd0) begin
      bad++;
      $display("FAIL wr_wrap: small retired=%0d, want 0", s_ret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
